// File: rtl/card_dealer.sv
// ============================================================================
// Module   : card_dealer
// Brief    : Issues cards from a captured shuffled deck for the opening deal
//            and in-game draws over a valid/ack handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module card_dealer #(
    parameter int DECK_SIZE   = 108,
    parameter int HAND_SIZE   = 7,
    parameter int NUM_PLAYERS = 2,
    parameter int MAX_DRAW    = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [6*DECK_SIZE-1:0] i_deck,
    input  logic                   i_load,
    input  logic                   i_deal_start,
    input  logic                   i_draw_req,
    input  logic [2:0]             i_draw_num,
    input  logic [1:0]             i_draw_player,
    input  logic                   i_ack,
    output logic [5:0]             o_card,
    output logic                   o_card_valid,
    output logic [1:0]             o_card_player,
    output logic                   o_discard,
    output logic [6:0]             o_remaining,
    output logic                   o_empty,
    output logic                   o_busy,
    output logic                   o_short
);

    localparam int         HAND_TOTAL   = NUM_PLAYERS * HAND_SIZE;
    localparam logic [6:0] DECK_END     = 7'(DECK_SIZE);
    localparam logic [6:0] HAND_TOTAL_L = 7'(HAND_TOTAL);
    localparam logic [1:0] LAST_PLAYER  = 2'(NUM_PLAYERS - 1);
    localparam logic [2:0] MAX_DRAW_L   = 3'(MAX_DRAW);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READY = 3'd1,
        S_DEAL  = 3'd2,
        S_DRAW  = 3'd3,
        S_EMPTY = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [6:0]             ptr_q, ptr_d;
    logic [6*DECK_SIZE-1:0] deck_q, deck_d;
    logic [6:0]             deal_idx_q, deal_idx_d;
    logic [2:0]             draw_cnt_q, draw_cnt_d;
    logic [5:0]             card_q, card_d;
    logic                   valid_q, valid_d;
    logic [1:0]             player_q, player_d;
    logic                   discard_q, discard_d;
    logic                   short_q, short_d;

    logic                   w_ack;
    logic [6:0]             w_ptr_inc;
    logic                   w_pile_out;
    logic [5:0]             w_cur_card;
    logic [5:0]             w_next_card;
    logic [1:0]             w_next_player;
    logic [6:0]             w_deal_next;
    logic [2:0]             w_draw_num;

    assign w_ack         = valid_q & i_ack;
    assign w_ptr_inc     = ptr_q + 7'd1;
    assign w_pile_out    = (w_ptr_inc == DECK_END);
    assign w_cur_card    = deck_q[int'(ptr_q)*6 +: 6];
    // Out-of-range read only happens when the pile is exhausted; it is never used then.
    assign w_next_card   = w_pile_out ? 6'd0 : deck_q[int'(w_ptr_inc)*6 +: 6];
    assign w_next_player = (player_q == LAST_PLAYER) ? 2'd0 : player_q + 2'd1;
    assign w_deal_next   = deal_idx_q + 7'd1;

    always_comb begin
        if (i_draw_num == 3'd0) begin
            w_draw_num = 3'd1;
        end else if (i_draw_num > MAX_DRAW_L) begin
            w_draw_num = MAX_DRAW_L;
        end else begin
            w_draw_num = i_draw_num;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        deck_d     = deck_q;
        deal_idx_d = deal_idx_q;
        draw_cnt_d = draw_cnt_q;
        card_d     = card_q;
        valid_d    = valid_q;
        player_d   = player_q;
        discard_d  = discard_q;
        short_d    = 1'b0;

        case (state_q)
            S_IDLE, S_EMPTY: begin
                if (i_load) begin
                    deck_d  = i_deck;
                    ptr_d   = 7'd0;
                    state_d = S_READY;
                end
            end

            S_READY: begin
                if (i_load) begin
                    deck_d = i_deck;
                    ptr_d  = 7'd0;
                end else if (i_deal_start && (ptr_q == 7'd0)) begin
                    state_d    = S_DEAL;
                    deal_idx_d = 7'd0;
                    valid_d    = 1'b1;
                    card_d     = w_cur_card;
                    player_d   = 2'd0;
                    discard_d  = (HAND_TOTAL_L == 7'd0);
                end else if (i_draw_req) begin
                    state_d    = S_DRAW;
                    draw_cnt_d = w_draw_num;
                    valid_d    = 1'b1;
                    card_d     = w_cur_card;
                    player_d   = i_draw_player;
                    discard_d  = 1'b0;
                end
            end

            S_DEAL: begin
                if (w_ack) begin
                    ptr_d = w_ptr_inc;
                    if (discard_q || w_pile_out) begin
                        valid_d   = 1'b0;
                        card_d    = 6'd0;
                        player_d  = 2'd0;
                        discard_d = 1'b0;
                        state_d   = w_pile_out ? S_EMPTY : S_READY;
                    end else begin
                        deal_idx_d = w_deal_next;
                        card_d     = w_next_card;
                        // The card after the last hand card is the flipped discard, owned by player 0.
                        discard_d  = (w_deal_next == HAND_TOTAL_L);
                        player_d   = (w_deal_next == HAND_TOTAL_L) ? 2'd0 : w_next_player;
                    end
                end
            end

            S_DRAW: begin
                if (w_ack) begin
                    ptr_d      = w_ptr_inc;
                    draw_cnt_d = draw_cnt_q - 3'd1;
                    if ((draw_cnt_q == 3'd1) || w_pile_out) begin
                        valid_d  = 1'b0;
                        card_d   = 6'd0;
                        player_d = 2'd0;
                        state_d  = w_pile_out ? S_EMPTY : S_READY;
                        // Only a draw cut short by exhaustion flags o_short.
                        short_d  = w_pile_out && (draw_cnt_q != 3'd1);
                    end else begin
                        card_d = w_next_card;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= 7'd0;
            deck_q     <= '0;
            deal_idx_q <= 7'd0;
            draw_cnt_q <= 3'd0;
            card_q     <= 6'd0;
            valid_q    <= 1'b0;
            player_q   <= 2'd0;
            discard_q  <= 1'b0;
            short_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            deck_q     <= deck_d;
            deal_idx_q <= deal_idx_d;
            draw_cnt_q <= draw_cnt_d;
            card_q     <= card_d;
            valid_q    <= valid_d;
            player_q   <= player_d;
            discard_q  <= discard_d;
            short_q    <= short_d;
        end
    end

    assign o_card        = card_q;
    assign o_card_valid  = valid_q;
    assign o_card_player = player_q;
    assign o_discard     = discard_q;
    assign o_remaining   = (state_q == S_IDLE) ? 7'd0 : (DECK_END - ptr_q);
    assign o_empty       = (state_q == S_EMPTY);
    assign o_busy        = (state_q == S_DEAL) || (state_q == S_DRAW);
    assign o_short       = short_q;

endmodule

`default_nettype wire

// File: tb/tb_card_dealer.sv
// ============================================================================
// Module   : tb_card_dealer
// Brief    : Randomized scoreboard bench for card_dealer against a deck/pointer
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_card_dealer;

    localparam int DECK = 108;
    localparam int HAND = 7;
    localparam int NP   = 2;
    localparam int MAXD = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [6*DECK-1:0] i_deck;
    logic              i_load, i_deal_start, i_draw_req, i_ack;
    logic [2:0]        i_draw_num;
    logic [1:0]        i_draw_player;
    logic [5:0]        o_card;
    logic              o_card_valid, o_discard, o_empty, o_busy, o_short;
    logic [1:0]        o_card_player;
    logic [6:0]        o_remaining;

    card_dealer #(
        .DECK_SIZE   (DECK),
        .HAND_SIZE   (HAND),
        .NUM_PLAYERS (NP),
        .MAX_DRAW    (MAXD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_deck        (i_deck),
        .i_load        (i_load),
        .i_deal_start  (i_deal_start),
        .i_draw_req    (i_draw_req),
        .i_draw_num    (i_draw_num),
        .i_draw_player (i_draw_player),
        .i_ack         (i_ack),
        .o_card        (o_card),
        .o_card_valid  (o_card_valid),
        .o_card_player (o_card_player),
        .o_discard     (o_discard),
        .o_remaining   (o_remaining),
        .o_empty       (o_empty),
        .o_busy        (o_busy),
        .o_short       (o_short)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] card;
        logic [1:0] player;
        logic       disc;
    } exp_t;

    exp_t sb[$];
    int   tests     = 0;
    int   fails     = 0;
    int   short_cnt = 0;
    int   exp_short = 0;
    int   n_acc     = 0;
    int   mdeck[DECK];
    int   mptr      = 0;
    int   ack_mode  = 0;
    bit   ack_tog   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Ack pattern: 0 = always, 1 = every other cycle, 2 = random.
    always @(posedge clk) begin
        #1;
        case (ack_mode)
            0:       i_ack = 1'b1;
            1:       begin ack_tog = ~ack_tog; i_ack = ack_tog; end
            default: i_ack = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: every presented card must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (o_short) short_cnt++;
            if (o_card_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected card", 1, 0);
                end else begin
                    check("card value", o_card, sb[0].card);
                    check("card player", o_card_player, sb[0].player);
                    check("card discard", o_discard, sb[0].disc);
                    if (i_ack) begin
                        void'(sb.pop_front());
                        n_acc++;
                    end
                end
            end
        end
    end

    task automatic pulse(input int which);
        @(posedge clk); #1;
        case (which)
            0:       i_load = 1'b1;
            1:       i_deal_start = 1'b1;
            default: i_draw_req = 1'b1;
        endcase
        @(posedge clk); #1;
        i_load = 1'b0; i_deal_start = 1'b0; i_draw_req = 1'b0;
    endtask

    task automatic wait_idle(input string name, output int cycles);
        cycles = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!o_busy) break;
            cycles++;
        end
        check({name, " finished"}, o_busy, 0);
    endtask

    task automatic finish_op(input string name);
        int cyc;
        wait_idle(name, cyc);
        @(negedge clk);
        check({name, " all delivered"}, sb.size(), 0);
        check({name, " short pulses"}, short_cnt, exp_short);
        check({name, " remaining"}, o_remaining, DECK - mptr);
        check({name, " empty"}, o_empty, (mptr == DECK));
    endtask

    task automatic load_deck(input bit rnd);
        logic [6*DECK-1:0] v;
        for (int i = 0; i < DECK; i++) begin
            mdeck[i] = rnd ? int'($urandom_range(0, 63)) : (i % 64);
            v[6*i +: 6] = 6'(mdeck[i]);
        end
        i_deck = v;
        pulse(0);
        mptr = 0;
        @(negedge clk);
        check("load remaining", o_remaining, DECK);
        check("load empty", o_empty, 0);
        check("load valid", o_card_valid, 0);
        check("load busy", o_busy, 0);
    endtask

    task automatic push_deal();
        for (int i = 0; i < NP*HAND; i++)
            sb.push_back('{6'(mdeck[mptr + i]), 2'(i % NP), 1'b0});
        sb.push_back('{6'(mdeck[mptr + NP*HAND]), 2'd0, 1'b1});
        mptr += NP*HAND + 1;
    endtask

    task automatic do_deal(input int mode);
        ack_mode = mode;
        push_deal();
        pulse(1);
        finish_op("deal");
    endtask

    task automatic do_draw(input int num, input int player, input int mode);
        int n, m;
        n = (num == 0) ? 1 : ((num > MAXD) ? MAXD : num);
        m = (n < DECK - mptr) ? n : DECK - mptr;
        for (int i = 0; i < m; i++)
            sb.push_back('{6'(mdeck[mptr + i]), 2'(player), 1'b0});
        mptr += m;
        if (m < n) exp_short++;
        ack_mode      = mode;
        i_draw_num    = 3'(num);
        i_draw_player = 2'(player);
        pulse(2);
        finish_op("draw");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, base, rem;
        reset = 1'b1; i_deck = '0; i_load = 1'b0; i_deal_start = 1'b0;
        i_draw_req = 1'b0; i_draw_num = 3'd0; i_draw_player = 2'd0; i_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset valid", o_card_valid, 0);
        check("reset busy", o_busy, 0);
        check("reset empty", o_empty, 0);
        check("reset remaining", o_remaining, 0);
        check("reset short", o_short, 0);

        load_deck(1'b0);

        // Opening deal with continuous ack: 15 back-to-back cards.
        ack_mode = 0;
        base = n_acc;
        push_deal();
        pulse(1);
        wait_idle("deal b2b", cyc);
        check("deal busy cycles", cyc, NP*HAND + 1);
        @(negedge clk);
        check("deal accepted", n_acc - base, NP*HAND + 1);
        check("deal drained", sb.size(), 0);
        check("deal remaining", o_remaining, 93);

        do_draw(4, 3, 1);
        check("stalled draw remaining", o_remaining, 89);
        do_draw(0, 1, 2);
        do_draw(7, 2, 2);
        check("clamp remaining", o_remaining, 84);

        for (int k = 0; k < 8; k++)
            do_draw(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));

        rem = DECK - mptr;
        while (rem > 2) begin
            do_draw((rem - 2 > 4) ? 4 : rem - 2, int'($urandom_range(0, 3)), 2);
            rem = DECK - mptr;
        end
        check("pre-exhaust remaining", o_remaining, 2);
        do_draw(4, 1, 0);
        check("exhaust short count", short_cnt, 1);
        check("exhaust empty", o_empty, 1);

        i_draw_num = 3'd2;
        pulse(2);
        repeat (3) @(negedge clk);
        check("ignored draw busy", o_busy, 0);
        check("ignored draw valid", o_card_valid, 0);
        check("ignored draw remaining", o_remaining, 0);
        check("ignored draw empty", o_empty, 1);

        load_deck(1'b1);
        do_deal(2);
        rem = DECK - mptr;
        while (rem > 0) begin
            do_draw((rem > 4) ? 4 : rem, int'($urandom_range(0, 3)), 2);
            rem = DECK - mptr;
        end
        check("exact empty no short", short_cnt, 1);
        check("exact empty flag", o_empty, 1);

        // Load arriving mid-draw is ignored; the draw continues from the old deck.
        load_deck(1'b1);
        ack_mode = 1;
        for (int i = 0; i < 4; i++)
            sb.push_back('{6'(mdeck[i]), 2'd2, 1'b0});
        mptr = 4;
        i_draw_num = 3'd4; i_draw_player = 2'd2;
        pulse(2);
        for (int i = 0; i < DECK; i++) i_deck[6*i +: 6] = 6'($urandom_range(0, 63));
        pulse(0);
        finish_op("draw during load");
        check("load ignored remaining", o_remaining, 104);

        // Asynchronous reset in the middle of the opening deal.
        load_deck(1'b1);
        ack_mode = 0;
        base = n_acc;
        push_deal();
        pulse(1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (n_acc - base >= 5) break;
        end
        check("deal reached 5 cards", n_acc - base, 5);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("midreset valid", o_card_valid, 0);
        check("midreset busy", o_busy, 0);
        check("midreset card", o_card, 0);
        check("midreset player", o_card_player, 0);
        check("midreset discard", o_discard, 0);
        check("midreset remaining", o_remaining, 0);
        check("midreset empty", o_empty, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        pulse(1);
        repeat (3) @(negedge clk);
        check("idle deal ignored busy", o_busy, 0);
        check("idle deal ignored valid", o_card_valid, 0);
        check("idle remaining", o_remaining, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
